// File: rtl/traffic_pkg.sv
// Shared FSM state encoding and per-phase {red,yellow,green} light codes
// for the traffic phase controller.
package traffic_pkg;

    typedef enum logic [2:0] {
        ST_GREEN  = 3'd0,
        ST_YELLOW = 3'd1,
        ST_ALLRED = 3'd2,
        ST_PED    = 3'd3,
        ST_FLASH  = 3'd4,
        ST_EMERG  = 3'd5
    } state_t;

    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

endpackage

// File: rtl/dwell_timer.sv
// Loadable down-counter that holds at zero; zero_o reflects the registered count.
// One-cycle load latency, freeze_i stalls the count, no backpressure.
module dwell_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] value_i,
    input  logic             freeze_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (!freeze_i && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Round-robin traffic signal controller with pedestrian, night-flash and emergency preemption.
// Outputs are registered copies of the next state, so they change one clock after the deciding inputs.
module traffic_phase_ctrl
    import traffic_pkg::*;
#(
    parameter int N_PHASE  = 4,
    parameter int CNT_W    = 8,
    parameter int T_GREEN  = 20,
    parameter int T_YELLOW = 3,
    parameter int T_ALLRED = 2,
    parameter int T_PED    = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       night_mode,
    input  logic                       emerg_req,
    input  logic [$clog2(N_PHASE)-1:0] emerg_phase,
    input  logic                       ped_req,
    output logic [3*N_PHASE-1:0]       light,
    output logic                       ped_walk,
    output logic [$clog2(N_PHASE)-1:0] cur_phase
);

    localparam int               PW        = $clog2(N_PHASE);
    localparam logic [PW-1:0]    LAST      = PW'(N_PHASE - 1);
    localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_GREEN - 1);
    localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] LD_ALLRED = CNT_W'(T_ALLRED - 1);
    localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(T_PED - 1);

    state_t               state_q, state_d;
    logic [PW-1:0]        phase_q, phase_d;
    logic [PW-1:0]        emerg_eff, phase_inc;
    logic                 ped_q, ped_d;
    logic                 flash_q, flash_d;
    logic [3*N_PHASE-1:0] light_q, light_d;
    logic                 walk_q, walk_d;
    logic                 tmr_load, tmr_freeze, tmr_zero;
    logic [CNT_W-1:0]     tmr_val;

    assign emerg_eff = (int'(emerg_phase) < N_PHASE) ? emerg_phase : '0;
    assign phase_inc = (phase_q == LAST) ? '0 : phase_q + PW'(1);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        flash_d    = flash_q;
        ped_d      = ped_q | ped_req;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_freeze = 1'b0;
        case (state_q)
            ST_GREEN: begin
                if (emerg_req && emerg_eff == phase_q) begin
                    tmr_freeze = 1'b1;
                end else if (emerg_req || tmr_zero) begin
                    state_d  = ST_YELLOW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_YELLOW;
                end
            end
            ST_YELLOW: begin
                if (tmr_zero) begin
                    state_d  = ST_ALLRED;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ALLRED;
                end
            end
            ST_ALLRED: begin
                // Clearance end is the only decision point for the special modes.
                if (tmr_zero) begin
                    if (emerg_req) begin
                        state_d = ST_EMERG;
                        phase_d = emerg_eff;
                    end else if (night_mode) begin
                        state_d  = ST_FLASH;
                        flash_d  = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = LD_YELLOW;
                    end else if (ped_q && phase_q == LAST) begin
                        state_d  = ST_PED;
                        ped_d    = ped_req;
                        tmr_load = 1'b1;
                        tmr_val  = LD_PED;
                    end else begin
                        state_d  = ST_GREEN;
                        phase_d  = phase_inc;
                        tmr_load = 1'b1;
                        tmr_val  = LD_GREEN;
                    end
                end
            end
            ST_PED: begin
                if (tmr_zero) begin
                    state_d  = ST_GREEN;
                    phase_d  = '0;
                    tmr_load = 1'b1;
                    tmr_val  = LD_GREEN;
                end
            end
            ST_FLASH: begin
                // Parking cur_phase on the last phase makes the rotation resume at phase 0.
                if (emerg_req || !night_mode) begin
                    state_d  = ST_ALLRED;
                    phase_d  = LAST;
                    tmr_load = 1'b1;
                    tmr_val  = LD_ALLRED;
                end else if (tmr_zero) begin
                    flash_d  = ~flash_q;
                    tmr_load = 1'b1;
                    tmr_val  = LD_YELLOW;
                end
            end
            ST_EMERG: begin
                if (!emerg_req || emerg_eff != phase_q) begin
                    state_d  = ST_YELLOW;
                    tmr_load = 1'b1;
                    tmr_val  = LD_YELLOW;
                end
            end
            default: begin
                state_d  = ST_ALLRED;
                tmr_load = 1'b1;
                tmr_val  = LD_ALLRED;
            end
        endcase
    end

    always_comb begin
        light_d = '0;
        for (int p = 0; p < N_PHASE; p++) begin
            light_d[3*p +: 3] = RED;
            if (state_d == ST_FLASH) begin
                light_d[3*p +: 3] = flash_d ? YEL : OFF;
            end else if (PW'(p) == phase_d) begin
                if (state_d == ST_GREEN || state_d == ST_EMERG) begin
                    light_d[3*p +: 3] = GRN;
                end else if (state_d == ST_YELLOW) begin
                    light_d[3*p +: 3] = YEL;
                end
            end
        end
        walk_d = (state_d == ST_PED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_ALLRED;
            phase_q <= LAST;
            ped_q   <= 1'b0;
            flash_q <= 1'b0;
            light_q <= {N_PHASE{RED}};
            walk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            ped_q   <= ped_d;
            flash_q <= flash_d;
            light_q <= light_d;
            walk_q  <= walk_d;
        end
    end

    dwell_timer #(
        .CNT_W  (CNT_W),
        .RST_VAL(LD_ALLRED)
    ) u_dwell_timer (
        .clk     (clk),
        .rst     (rst),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .freeze_i(tmr_freeze),
        .zero_o  (tmr_zero)
    );

    assign light     = light_q;
    assign ped_walk  = walk_q;
    assign cur_phase = phase_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Scoreboard bench: a mode/elapsed-time reference model predicts every cycle's outputs.
module tb_traffic_phase_ctrl;

    localparam int N  = 4;
    localparam int TG = 5;
    localparam int TY = 2;
    localparam int TA = 1;
    localparam int TP = 3;

    localparam int M_GREEN = 0, M_YELLOW = 1, M_ALLRED = 2, M_PED = 3, M_FLASH = 4, M_EMERG = 5;

    localparam logic [11:0] ALL_RED  = 12'h924;
    localparam logic [11:0] G0_ONLY  = 12'h921;
    localparam logic [11:0] Y0_ONLY  = 12'h922;
    localparam logic [11:0] ALL_YEL  = 12'h492;
    localparam logic [11:0] ALL_DARK = 12'h000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        night_mode = 1'b0;
    logic        emerg_req = 1'b0;
    logic [1:0]  emerg_phase = 2'd0;
    logic        ped_req = 1'b0;
    logic [11:0] light;
    logic        ped_walk;
    logic [1:0]  cur_phase;

    traffic_phase_ctrl #(
        .N_PHASE(N), .CNT_W(8), .T_GREEN(TG), .T_YELLOW(TY), .T_ALLRED(TA), .T_PED(TP)
    ) dut (
        .clk(clk), .rst(rst), .night_mode(night_mode), .emerg_req(emerg_req),
        .emerg_phase(emerg_phase), .ped_req(ped_req),
        .light(light), .ped_walk(ped_walk), .cur_phase(cur_phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] light;
        logic        walk;
        logic [1:0]  ph;
        logic        flash;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;

    // Reference model: which mode we are in, which phase, and how many cycles spent there.
    int m_mode = M_ALLRED;
    int m_ph   = N - 1;
    int m_age  = 1;
    bit m_pend = 1'b0;
    bit m_lit  = 1'b0;

    function automatic int dwell(input int mode);
        case (mode)
            M_GREEN:  return TG;
            M_YELLOW: return TY;
            M_ALLRED: return TA;
            M_PED:    return TP;
            M_FLASH:  return TY;
            default:  return 0;
        endcase
    endfunction

    function void enter(input int mode);
        m_mode = mode;
        m_age  = 1;
    endfunction

    function void step_model();
        bit done;
        bit pend_next;
        int eph;
        done      = (m_age >= dwell(m_mode));
        eph       = (int'(emerg_phase) < N) ? int'(emerg_phase) : 0;
        pend_next = m_pend | ped_req;
        case (m_mode)
            M_GREEN: begin
                if (emerg_req && eph == m_ph) begin
                end else if (emerg_req || done) enter(M_YELLOW);
                else m_age++;
            end
            M_YELLOW: if (done) enter(M_ALLRED); else m_age++;
            M_ALLRED: begin
                if (!done) m_age++;
                else if (emerg_req) begin m_ph = eph; enter(M_EMERG); end
                else if (night_mode) begin m_lit = 1'b1; enter(M_FLASH); end
                else if (m_pend && m_ph == N - 1) begin pend_next = ped_req; enter(M_PED); end
                else begin m_ph = (m_ph + 1) % N; enter(M_GREEN); end
            end
            M_PED: if (done) begin m_ph = 0; enter(M_GREEN); end else m_age++;
            M_FLASH: begin
                if (emerg_req || !night_mode) begin m_ph = N - 1; enter(M_ALLRED); end
                else if (done) begin m_lit = !m_lit; m_age = 1; end
                else m_age++;
            end
            default: if (!emerg_req || eph != m_ph) enter(M_YELLOW);
        endcase
        m_pend = pend_next;
    endfunction

    function automatic exp_t expect_now();
        exp_t e;
        e = '0;
        for (int p = 0; p < N; p++) begin
            if (m_mode == M_FLASH) e.light[3*p +: 3] = m_lit ? 3'b010 : 3'b000;
            else if (p == m_ph && (m_mode == M_GREEN || m_mode == M_EMERG)) e.light[3*p +: 3] = 3'b001;
            else if (p == m_ph && m_mode == M_YELLOW) e.light[3*p +: 3] = 3'b010;
            else e.light[3*p +: 3] = 3'b100;
        end
        e.walk  = (m_mode == M_PED);
        e.ph    = 2'(m_ph);
        e.flash = (m_mode == M_FLASH);
        return e;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_mode = M_ALLRED; m_ph = N - 1; m_age = 1; m_pend = 1'b0; m_lit = 1'b0;
        end else begin
            step_model();
        end
        sb.push_back(expect_now());
    end

    function void cmp(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endfunction

    exp_t mon_e;
    bit   mon_bad;
    int   mon_nonred;
    logic [2:0] mon_f;

    always @(posedge clk) begin
        #1;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty actual=0 required=1 time=%0t", $time);
        end else begin
            mon_e = sb.pop_front();
            cmp("light", 32'(light), 32'(mon_e.light));
            cmp("ped_walk", 32'(ped_walk), 32'(mon_e.walk));
            cmp("cur_phase", 32'(cur_phase), 32'(mon_e.ph));
            mon_bad = 1'b0;
            mon_nonred = 0;
            for (int p = 0; p < N; p++) begin
                mon_f = light[3*p +: 3];
                if (!(mon_f inside {3'b000, 3'b001, 3'b010, 3'b100})) mon_bad = 1'b1;
                if (mon_f == 3'b000 && !mon_e.flash) mon_bad = 1'b1;
                if (mon_f != 3'b100) mon_nonred++;
            end
            if (!mon_e.flash && mon_nonred > 1) mon_bad = 1'b1;
            cmp("light_invariant", 32'(mon_bad), 32'd0);
        end
    end

    task automatic wait_light(input int ph, input logic [2:0] code, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            if (light[3*ph +: 3] === code) return;
        end
        checks++;
        failures++;
        $display("FAIL wait_phase%0d_code%0b actual=timeout required=seen", ph, code);
    endtask

    int cyc;
    int len;
    bit left;

    initial begin
        // Reset and plain rotation.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("first_green", 32'(light), 32'(G0_ONLY));
        cmp("first_phase", 32'(cur_phase), 32'd0);
        cyc = 0;
        left = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            cyc++;
            if (light[2:0] !== 3'b001) left = 1'b1;
            else if (left) break;
        end
        cmp("cycle_len", 32'(cyc), 32'd32);

        // Pedestrian request during phase 1 green.
        wait_light(1, 3'b001, 100);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        for (int i = 0; i < 100 && ped_walk !== 1'b1; i++) @(negedge clk);
        len = 0;
        while (ped_walk === 1'b1 && len < 10) begin
            cmp("ped_allred", 32'(light), 32'(ALL_RED));
            len++;
            @(negedge clk);
        end
        cmp("ped_len", 32'(len), 32'(TP));
        cmp("after_ped_g0", 32'(light), 32'(G0_ONLY));

        // Emergency preemption of phase 2 during phase 0 green.
        wait_light(0, 3'b001, 100);
        emerg_phase = 2'd2;
        emerg_req = 1'b1;
        @(negedge clk);
        cmp("emerg_yellow", 32'(light), 32'(Y0_ONLY));
        repeat (9) @(negedge clk);
        emerg_req = 1'b0;
        wait_light(3, 3'b001, 50);
        cmp("emerg_resume", 32'(cur_phase), 32'd3);

        // Night flash entered during phase 1 green.
        wait_light(1, 3'b001, 100);
        night_mode = 1'b1;
        for (int i = 0; i < 20 && light !== ALL_YEL; i++) @(negedge clk);
        @(negedge clk);
        cmp("flash_on2", 32'(light), 32'(ALL_YEL));
        @(negedge clk);
        cmp("flash_off1", 32'(light), 32'(ALL_DARK));
        @(negedge clk);
        cmp("flash_off2", 32'(light), 32'(ALL_DARK));
        @(negedge clk);
        cmp("flash_on1", 32'(light), 32'(ALL_YEL));
        repeat (5) @(negedge clk);
        night_mode = 1'b0;
        @(negedge clk);
        cmp("night_exit_allred", 32'(light), 32'(ALL_RED));
        @(negedge clk);
        cmp("night_exit_g0", 32'(light), 32'(G0_ONLY));

        // Reset during phase 2 yellow with a pedestrian request pending.
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        wait_light(2, 3'b010, 100);
        rst = 1'b1;
        #1;
        cmp("rst_async_light", 32'(light), 32'(ALL_RED));
        cmp("rst_async_phase", 32'(cur_phase), 32'd3);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        cmp("rst_release_g0", 32'(light), 32'(G0_ONLY));
        len = 0;
        repeat (40) begin
            @(negedge clk);
            if (ped_walk === 1'b1) len++;
        end
        cmp("rst_cleared_ped", 32'(len), 32'd0);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 2500; i++) begin
            ped_req = ($urandom_range(0, 19) == 0);
            if (night_mode ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 149) == 0))
                night_mode = ~night_mode;
            if (emerg_req ? ($urandom_range(0, 14) == 0) : ($urandom_range(0, 59) == 0))
                emerg_req = ~emerg_req;
            if ($urandom_range(0, 24) == 0) emerg_phase = 2'($urandom_range(0, 3));
            rst = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        ped_req = 1'b0;
        night_mode = 1'b0;
        emerg_req = 1'b0;
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
